round_key_store: RTL and testbench

ROUND_KEY_STORE -- requirements
Module: round_key_store

---
 rtl/aes_pkg.sv | 17 +
 rtl/rks_regfile.sv | 37 +++
 rtl/round_key_store.sv | 193 +++++++++++++++++++
 tb/tb_round_key_store.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-store types: round count, key width, round-index width, store FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;
  localparam int RND_W = 4;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2,
    ST_STREAM  = 2'd3
  } rks_state_t;

endpackage

// File: rtl/rks_regfile.sv
// Round-key storage: DEPTH x KEY_W array, one write port, one registered read port.
// Latency: read data valid the cycle after re; write lands on the clock edge.
// Backpressure: none; rdata holds its value whenever re is low.
module rks_regfile #(
  parameter int DEPTH = 11,
  parameter int KEY_W = 128,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [KEY_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [KEY_W-1:0] rdata
);

  logic [KEY_W-1:0] mem [DEPTH];

  // Key array write; the array itself is never reset, only overwritten.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; output cleared by reset so the stream data bus starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (int'(raddr) < DEPTH) ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/round_key_store.sv
// AES round-key store: fill NR+1 keys, then stream them up or down; ROUND_KEY_STORE_ZEROIZE_EN adds a wipe.
// Latency: first beat one cycle after an accepted rd_start; then one beat per cycle with no bubbles.
// Backpressure: rk_valid/rk_data/rk_round/rk_last hold while rk_ready is low.
module round_key_store #(
  parameter int NR    = aes_pkg::NR,
  parameter int KEY_W = aes_pkg::KEY_W
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
  input  logic                      zeroize,
`endif
  input  logic                      init_valid,
  input  logic [KEY_W-1:0]          init_key,
  input  logic [KEY_W-1:0]          key_in,
  input  logic [aes_pkg::RND_W-1:0] key_addr,
  input  logic                      key_loaded,
  input  logic                      rd_start,
  input  logic                      rd_dir,
  output logic                      rk_valid,
  input  logic                      rk_ready,
  output logic [KEY_W-1:0]          rk_data,
  output logic [aes_pkg::RND_W-1:0] rk_round,
  output logic                      rk_last,
  output logic                      full,
  output logic                      rd_err
);
  import aes_pkg::*;

  localparam int              RW       = aes_pkg::RND_W;
  localparam logic [RW-1:0]   LAST_RND = RW'(NR);

  rks_state_t     state;
  logic [NR:0]    bitmap;
  logic           dir_q;
  logic           zero_busy;
  logic [RW-1:0]  zero_addr;

  logic           we;
  logic [RW-1:0]  waddr;
  logic [KEY_W-1:0] wdata;
  logic           re;
  logic [RW-1:0]  raddr;

  logic           xfer;
  logic           fill_hit;
  logic [RW-1:0]  nxt_round;
  logic [RW-1:0]  first_rnd;
  logic [RW-1:0]  end_rnd;

`ifdef ROUND_KEY_STORE_ZEROIZE_EN
  logic           zero_active;
  logic [RW-1:0]  zero_cnt;

  // The trigger cycle wipes entry 0; the sequencer then walks entries 1..NR.
  assign zero_busy = zero_active | zeroize;
  assign zero_addr = zero_active ? zero_cnt : '0;

  // Wipe sequencer: one entry per cycle until entry NR is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_active <= 1'b0;
      zero_cnt    <= '0;
    end else if (!zero_active && zeroize) begin
      zero_active <= 1'b1;
      zero_cnt    <= RW'(1);
    end else if (zero_active) begin
      if (zero_cnt == LAST_RND) zero_active <= 1'b0;
      zero_cnt <= zero_cnt + 1'b1;
    end
  end
`else
  assign zero_busy = 1'b0;
  assign zero_addr = '0;
`endif

  assign xfer      = rk_valid & rk_ready;
  assign fill_hit  = (state == ST_FILLING) && (key_addr != '0) && (key_addr <= LAST_RND);
  assign nxt_round = dir_q ? (rk_round - 1'b1) : (rk_round + 1'b1);
  assign first_rnd = rd_dir ? LAST_RND : '0;
  assign end_rnd   = dir_q ? '0 : LAST_RND;
  assign full      = (state == ST_FULL) || (state == ST_STREAM);

  // Write-port select: wipe beats init, init beats expansion writes.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (zero_busy) begin
      we    = 1'b1;
      waddr = zero_addr;
    end else if (init_valid) begin
      we    = 1'b1;
      wdata = init_key;
    end else if (fill_hit) begin
      we    = 1'b1;
      waddr = key_addr;
      wdata = key_in;
    end
  end

  // Read-port select: fetch the first key on start, the next key on each non-final transfer.
  always_comb begin
    re    = 1'b0;
    raddr = '0;
    if (!zero_busy && !init_valid) begin
      if ((state == ST_FULL) && rd_start) begin
        re    = 1'b1;
        raddr = first_rnd;
      end else if ((state == ST_STREAM) && xfer && !rk_last) begin
        re    = 1'b1;
        raddr = nxt_round;
      end
    end
  end

  rks_regfile #(
    .DEPTH (NR + 1),
    .KEY_W (KEY_W),
    .AW    (RW)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rk_data)
  );

  // Store FSM with registered stream controls; wipe and init take priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      bitmap   <= '0;
      dir_q    <= 1'b0;
      rk_valid <= 1'b0;
      rk_round <= '0;
      rk_last  <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_err <= 1'b0;
      if (zero_busy) begin
        state    <= ST_EMPTY;
        bitmap   <= '0;
        rk_valid <= 1'b0;
        rk_last  <= 1'b0;
        rd_err   <= rd_start;
      end else if (init_valid) begin
        state    <= ST_FILLING;
        bitmap   <= {{NR{1'b0}}, 1'b1};
        rk_valid <= 1'b0;
        rk_last  <= 1'b0;
      end else begin
        case (state)
          ST_EMPTY: begin
            rd_err <= rd_start;
          end
          ST_FILLING: begin
            rd_err <= rd_start;
            if (fill_hit) bitmap[key_addr] <= 1'b1;
            if ((&bitmap) && key_loaded) state <= ST_FULL;
          end
          ST_FULL: begin
            if (rd_start) begin
              state    <= ST_STREAM;
              rk_valid <= 1'b1;
              rk_round <= first_rnd;
              rk_last  <= 1'b0;
              dir_q    <= rd_dir;
            end
          end
          ST_STREAM: begin
            rd_err <= rd_start;
            if (xfer) begin
              if (rk_last) begin
                state    <= ST_FULL;
                rk_valid <= 1'b0;
                rk_last  <= 1'b0;
              end else begin
                rk_round <= nxt_round;
                rk_last  <= (nxt_round == end_rnd);
              end
            end
          end
          default: state <= ST_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_round_key_store.sv
// Self-checking bench for round_key_store: scoreboard queue of expected beats, separate monitor.
// Latency: n/a.
// Backpressure: rk_ready driven by per-test patterns.
module tb_round_key_store;

  logic         clk = 1'b0;
  logic         rst;
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
  logic         zeroize;
`endif
  logic         init_valid;
  logic [127:0] init_key;
  logic [127:0] key_in;
  logic [3:0]   key_addr;
  logic         key_loaded;
  logic         rd_start;
  logic         rd_dir;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         full;
  logic         rd_err;

  always #5 clk = ~clk;

  round_key_store dut (
    .clk        (clk),
    .rst        (rst),
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .init_valid (init_valid),
    .init_key   (init_key),
    .key_in     (key_in),
    .key_addr   (key_addr),
    .key_loaded (key_loaded),
    .rd_start   (rd_start),
    .rd_dir     (rd_dir),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_data    (rk_data),
    .rk_round   (rk_round),
    .rk_last    (rk_last),
    .full       (full),
    .rd_err     (rd_err)
  );

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] dat;
    logic         last;
  } beat_t;

  beat_t        sb_q[$];
  logic [127:0] exp_mem [11];
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] kv(input int r, input int seed);
    return {4{8'(seed), 16'hBEEF, 8'(r)}};
  endfunction

  // Monitor: every presented beat must match the head of the queue; pop on transfer.
  always @(negedge clk) begin
    if (!rst && rk_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: round %0d presented, none expected", rk_round);
      end else begin
        check("beat_round", 128'(rk_round), 128'(sb_q[0].rnd));
        check("beat_data",  rk_data,         sb_q[0].dat);
        check("beat_last",  128'(rk_last),  128'(sb_q[0].last));
        if (rk_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [127:0] k);
    init_valid = 1'b1;
    init_key   = k;
    tick();
    init_valid = 1'b0;
    exp_mem[0] = k;
  endtask

  task automatic wr(input int a, input logic [127:0] d);
    key_addr = 4'(a);
    key_in   = d;
    tick();
    key_addr = 4'd0;
  endtask

  task automatic push_stream(input logic dir);
    for (int i = 0; i <= 10; i++) begin
      int r;
      r = dir ? 10 - i : i;
      sb_q.push_back('{rnd: 4'(r), dat: exp_mem[r], last: (i == 10)});
    end
  endtask

  task automatic run_stream(input logic dir, input logic [3:0] pat, output int cyc);
    push_stream(dir);
    rd_dir   = dir;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 200) begin
      rk_ready = pat[cyc % 4];
      tick();
      cyc++;
    end
    rk_ready = 1'b1;
    if (cyc >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_timeout: %0d beats still pending", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rk_valid"}, 128'(rk_valid), 128'd0);
    check({tag, "_rk_data"},  rk_data,        128'd0);
    check({tag, "_rk_round"}, 128'(rk_round), 128'd0);
    check({tag, "_rk_last"},  128'(rk_last),  128'd0);
    check({tag, "_full"},     128'(full),     128'd0);
    check({tag, "_rd_err"},   128'(rd_err),   128'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int ord2 [10] = '{10, 3, 7, 1, 2, 4, 5, 6, 8, 9};
    rst = 1'b1;
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    init_valid = 1'b0; init_key = '0; key_in = '0; key_addr = '0;
    key_loaded = 1'b0; rd_start = 1'b0; rd_dir = 1'b0; rk_ready = 1'b1;
    tick(); tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    tick();

    // Ascending fill, encrypt-order stream with rk_ready held high.
    do_init(128'h000102030405060708090a0b0c0d0e0f);
    for (int a = 1; a <= 10; a++) begin
      wr(a, kv(a, 1));
      exp_mem[a] = kv(a, 1);
    end
    tick();
    check("full_needs_key_loaded", 128'(full), 128'd0);
    key_loaded = 1'b1;
    tick();
    check("full_after_fill", 128'(full), 128'd1);
    run_stream(1'b0, 4'b1111, cyc);
    check("asc_cycles", 128'(cyc), 128'd11);
    tick();
    check("asc_done_valid", 128'(rk_valid), 128'd0);
    check("asc_done_full",  128'(full),     128'd1);

    // Out-of-order fill with ignored addresses 0 and 11, decrypt-order stream.
    key_loaded = 1'b0;
    do_init(kv(0, 2));
    for (int i = 0; i < 10; i++) begin
      wr(ord2[i], kv(ord2[i], 2));
      exp_mem[ord2[i]] = kv(ord2[i], 2);
      if (i == 3) begin
        wr(0,  kv(0, 99));
        wr(11, kv(11, 99));
      end
    end
    key_loaded = 1'b1;
    tick();
    check("full_after_ooo_fill", 128'(full), 128'd1);
    run_stream(1'b1, 4'b1111, cyc);
    check("desc_cycles", 128'(cyc), 128'd11);

    // Writes in FULL are ignored; stream with rk_ready pattern 1,0,0,1.
    wr(5, kv(5, 77));
    wr(0, kv(0, 77));
    run_stream(1'b0, 4'b1001, cyc);
    check("stall_stream_len", 128'(cyc), 128'd21);

    // rd_start while FILLING with bitmap 0x3FF is rejected.
    key_loaded = 1'b0;
    do_init(kv(0, 3));
    for (int a = 1; a <= 9; a++) begin
      wr(a, kv(a, 3));
      exp_mem[a] = kv(a, 3);
    end
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("rd_err_pulse",      128'(rd_err),   128'd1);
    check("rd_err_no_valid",   128'(rk_valid), 128'd0);
    tick();
    check("rd_err_one_cycle",  128'(rd_err),   128'd0);
    wr(10, kv(10, 3));
    exp_mem[10] = kv(10, 3);
    key_loaded = 1'b1;
    tick();
    check("full_after_late_fill", 128'(full), 128'd1);

    // init_valid while beat 4 is presented aborts the stream.
    push_stream(1'b0);
    rd_dir = 1'b0; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (4) tick();
    key_loaded = 1'b0;
    do_init(kv(0, 5));
    check("abort_valid",   128'(rk_valid),    128'd0);
    check("abort_full",    128'(full),        128'd0);
    check("abort_pending", 128'(sb_q.size()), 128'd6);
    sb_q.delete();
    for (int a = 1; a <= 10; a++) begin
      wr(a, kv(a, 5));
      exp_mem[a] = kv(a, 5);
    end
    key_loaded = 1'b1;
    tick();
    check("refill_full", 128'(full), 128'd1);
    run_stream(1'b1, 4'b1111, cyc);
    check("refill_desc_cycles", 128'(cyc), 128'd11);

    // Synchronous reset mid-stream clears every output next cycle.
    push_stream(1'b0);
    rd_dir = 1'b0; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_zero_outputs("midrst");
    rst = 1'b0;
    sb_q.delete();
    repeat (3) tick();
    check("post_rst_full", 128'(full), 128'd0);

`ifdef ROUND_KEY_STORE_ZEROIZE_EN
    // Wipe from FULL: full drops, rd_start rejected, every entry cleared.
    do_init(kv(0, 7));
    for (int a = 1; a <= 10; a++) wr(a, kv(a, 7));
    key_loaded = 1'b1;
    tick();
    check("zf_full", 128'(full), 128'd1);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    check("zf_full_drop", 128'(full), 128'd0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("zf_rd_err", 128'(rd_err), 128'd1);
    repeat (10) tick();
    check("zf_full_end", 128'(full), 128'd0);
    for (int i = 0; i <= 10; i++) check("zf_entry", dut.u_rf.mem[i], 128'd0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
